uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the team's oversampled UART receiver.
- Serialises N_BIT-wide words as: start bit, data LSB first, optional parity bit, stop period.
- Uses the same baud-rate TICK strobe as the receiver (N_TICK ticks per bit).
- Includes a one-entry holding register, so a host can queue the next word during a frame and frames go out back-to-back.

Parameters:
- N_BIT, 8, data bits per frame (2..16).
- N_TICK, 16, TICK strobes per start, data or parity bit.
- SB_TICK, 16, TICK strobes in the stop period (16/24/32 = 1/1.5/2 stop bits at N_TICK=16).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- CLK, input, 1, system clock.
- RESET, input, 1, asynchronous active-high reset.
- TICK, input, 1, single-cycle baud-oversample strobe.
- TX_START, input, 1, write strobe for DIN; accepted only when TX_READY=1.
- DIN, input, N_BIT, word to transmit.
- TX, output, 1, serial line; registered; idles high.
- TX_DONE, output, 1, one-CLK pulse when a frame's stop period ends.
- TX_READY, output, 1, 1 = holding register empty; TX_START will be accepted.
- TX_BUSY, output, 1, 1 while state != idle.
- STATE, output, 3, current FSM state (debug).

Behaviour:
- Interface: clock CLK; reset RESET, asynchronous, active-high.
- Reset values: TX=1, TX_DONE=0, TX_READY=1, TX_BUSY=0, STATE=idle(0). Internal state also clears: tick count s=0, bit index n=0, shift register b=0, holding register empty.
- Reset mid-frame: TX returns high at once, the holding register is dropped, and no TX_DONE is produced.
- States: idle=0, start=1, data=2, parity=3, stop=4. Encodings 5-7 are illegal and go to idle.
- TX value per state: idle=1, start=0, data=b[0], parity=par, stop=1. TX is registered and updates on the same edge as the state.
- Counting: s increments only on TICK, and is cleared to 0 on every state transition.
- Acceptance when idle: TX_START=1 at edge k gives b<=DIN, par<=^DIN^PARITY_ODD, state=start, and TX=0 after edge k (1-cycle latency). The holding register stays empty.
- Acceptance when busy: TX_START=1 with TX_READY=1 stores DIN in the holding register. TX_READY drops after that edge.
- TX_START with TX_READY=0 is ignored; the word is dropped and no state changes.
- start -> data: on TICK with s==N_TICK-1. n is cleared to 0.
- data, bit advance: on TICK with s==N_TICK-1, b shifts right by one.
  - If n==N_BIT-1: go to parity (PARITY_EN=1) or to stop.
  - Otherwise n increments.
- parity -> stop: on TICK with s==N_TICK-1.
- stop end: on TICK with s==SB_TICK-1, TX_DONE=1 for exactly that cycle, then the next frame source is chosen in priority order:
  1. Holding register full: load b and par from it, empty it (TX_READY=1), go to start.
  2. Otherwise, TX_START=1 in the same cycle: load DIN directly, go to start.
  3. Otherwise: go to idle.
- In cases 1 and 2 there is no idle cycle between frames: TX goes 1→0 directly at the frame boundary.
- Frame length: (1 + N_BIT + PARITY_EN)·N_TICK + SB_TICK ticks.
- TICK held high continuously is legal: one tick per clock.
- Counter widths:
  - s: $clog2(max(N_TICK,SB_TICK)) bits.
  - n: $clog2(N_BIT) bits.
  - Neither counter may wrap inside a state.

Decomposition:
- Shared package uart_pkg holds:
  - UART state encoding constants (idle/start/data/parity/stop; the receiver uses the idle..stop subset);
  - default N_BIT/N_TICK;
  - a parity helper function.
- One natural sub-module: uart_tx_hold, the one-entry holding register with TX_READY/accept/consume handshake (about 40 lines). The FSM and shifter stay in uart_tx.

Test Plan:
1. Single word, defaults, TICK every cycle, DIN=0xA5:
   - TX=0 for 16 cycles, then data 1,0,1,0,0,1,0,1 at 16 cycles each, then TX=1 for 16 cycles.
   - TX_DONE pulses once, 160 cycles after the start edge.
   - TX_BUSY=1 for all 160 cycles.
2. Back-to-back, DIN=0x55 then 0x0F written during the first frame's data phase:
   - TX_READY=0 after the second write; a third TX_START (0xFF) is ignored.
   - Two TX_DONE pulses 160 cycles apart; stop→start with no idle cycle.
   - Serial stream shows only 0x55 and 0x0F.
3. Parity, PARITY_EN=1, DIN=0x07:
   - PARITY_ODD=0: parity bit 1; PARITY_ODD=1: parity bit 0.
   - Frame is 176 ticks.
4. Slow TICK (every 4th cycle) with SB_TICK=32:
   - Frame is 9·16·4 + 32·4 = 704 cycles.
   - TX transitions only on TICK-aligned edges.
5. RESET asserted mid-data bit 3:
   - TX=1 immediately (same cycle, asynchronous); TX_READY=1, STATE=0.
   - No TX_DONE.
   - The next TX_START produces a clean full frame.
6. Loopback of TX into the receiver, 256 random words with random inter-word gaps:
   - Every RX_DONE shows DOUT equal to the sent word.
   - Count of TX_DONE pulses equals count of RX_DONE pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, defaults and parity helper
//   ST_IDLE..ST_STOP : FSM encodings shared by transmitter and receiver
//   UART_N_BIT_DEF   : default data bits per frame
//   UART_N_TICK_DEF  : default TICK strobes per bit
//   uart_parity()    : parity bit for a word (zero-extend to 16 bits)
package uart_pkg;

  localparam int UART_N_BIT_DEF  = 8;
  localparam int UART_N_TICK_DEF = 16;

  // The receiver only uses the idle..stop subset it needs; parity is tx-side.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Even parity when odd=0: the returned bit makes the total count of ones even.
  function automatic logic uart_parity(input logic [15:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// rtl/uart_tx_hold.sv - one-entry holding register between host and shifter
//   CLK, RESET : clock, asynchronous active-high reset (drops any held word)
//   WR, WDATA  : store WDATA; ignored while FULL
//   RD         : consume the held word; ignored while empty
//   RDATA      : held word
//   FULL       : 1 = a word is held (host sees TX_READY = !FULL)
module uart_tx_hold #(
  parameter int N_BIT = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WR,
  input  logic [N_BIT-1:0] WDATA,
  input  logic             RD,
  output logic [N_BIT-1:0] RDATA,
  output logic             FULL
);

  logic [N_BIT-1:0] data;
  logic             full;

  // WR needs an empty slot and RD a full one, so they never act together.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data <= '0;
      full <= 1'b0;
    end else if (WR && !full) begin
      data <= WDATA;
      full <= 1'b1;
    end else if (RD && full) begin
      full <= 1'b0;
    end
  end

  assign RDATA = data;
  assign FULL  = full;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - oversampled UART transmitter with one-word holding register
//   CLK, RESET : clock, asynchronous active-high reset
//   TICK       : baud oversample strobe (N_TICK per bit, SB_TICK per stop period)
//   TX_START   : write strobe for DIN, taken only while TX_READY=1
//   DIN        : word to send, LSB first
//   TX         : registered serial line, idles high
//   TX_DONE    : one-cycle pulse as each stop period ends
//   TX_READY   : holding register empty
//   TX_BUSY    : FSM not idle
//   STATE      : FSM state for debug
module uart_tx
  import uart_pkg::*;
#(
  parameter int N_BIT      = UART_N_BIT_DEF,
  parameter int N_TICK     = UART_N_TICK_DEF,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK,
  input  logic             TX_START,
  input  logic [N_BIT-1:0] DIN,
  output logic             TX,
  output logic             TX_DONE,
  output logic             TX_READY,
  output logic             TX_BUSY,
  output logic [2:0]       STATE
);

  localparam int S_MAX = (N_TICK > SB_TICK) ? N_TICK : SB_TICK;
  localparam int S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int N_W   = $clog2(N_BIT);

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(N_TICK - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(N_BIT - 1);
  localparam logic           ODD         = (PARITY_ODD != 0);
  localparam logic           PAR_EN      = (PARITY_EN != 0);

  uart_state_t      state;
  logic [S_W-1:0]   s;
  logic [N_W-1:0]   n;
  logic [N_BIT-1:0] b;
  logic             par;
  logic             tx_r;
  logic             done_r;

  logic             hold_full;
  logic [N_BIT-1:0] hold_data;
  logic             hold_wr;
  logic             hold_rd;
  logic             bit_end;
  logic             stop_end;

  assign bit_end  = TICK && (s == S_BIT_LAST);
  assign stop_end = (state == ST_STOP) && TICK && (s == S_STOP_LAST);

  // While idle, and at a stop end with nothing held, the FSM takes DIN
  // directly, so the holding register only fills during a frame.
  assign hold_wr = TX_START && !hold_full && (state != ST_IDLE) && !stop_end;
  assign hold_rd = stop_end && hold_full;

  uart_tx_hold #(
    .N_BIT (N_BIT)
  ) u_hold (
    .CLK   (CLK),
    .RESET (RESET),
    .WR    (hold_wr),
    .WDATA (DIN),
    .RD    (hold_rd),
    .RDATA (hold_data),
    .FULL  (hold_full)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      par    <= 1'b0;
      tx_r   <= 1'b1;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // Tick counter runs only inside a frame; every transition below
      // overrides this with a clear.
      if (TICK && (state != ST_IDLE))
        s <= s + S_W'(1);

      case (state)
        ST_IDLE: begin
          s <= '0;
          if (TX_START) begin
            b     <= DIN;
            par   <= uart_parity(16'(DIN), ODD);
            state <= ST_START;
            tx_r  <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            s     <= '0;
            n     <= '0;
            tx_r  <= b[0];
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            s <= '0;
            b <= b >> 1;
            if (n == N_LAST) begin
              if (PAR_EN) begin
                state <= ST_PARITY;
                tx_r  <= par;
              end else begin
                state <= ST_STOP;
                tx_r  <= 1'b1;
              end
            end else begin
              n    <= n + N_W'(1);
              tx_r <= b[1];           // next LSB after this edge's shift
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            s     <= '0;
            tx_r  <= 1'b1;
          end
        end

        ST_STOP: begin
          if (stop_end) begin
            done_r <= 1'b1;
            s      <= '0;
            // Held word first, then a same-cycle write, else go idle; the
            // first two chain frames with no idle bit in between.
            if (hold_full) begin
              b     <= hold_data;
              par   <= uart_parity(16'(hold_data), ODD);
              state <= ST_START;
              tx_r  <= 1'b0;
            end else if (TX_START) begin
              b     <= DIN;
              par   <= uart_parity(16'(DIN), ODD);
              state <= ST_START;
              tx_r  <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx_r  <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          s     <= '0;
          tx_r  <= 1'b1;
        end
      endcase
    end
  end

  assign TX       = tx_r;
  assign TX_DONE  = done_r;
  assign TX_READY = !hold_full;
  assign TX_BUSY  = (state != ST_IDLE);
  assign STATE    = state;

endmodule
